// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and baud divisor.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Clocks per bit, truncated; uart_transmit uses the same divisor.
  function automatic int baud_period(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs; RESET_VAL sets the idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver: start-bit detect, centre sampling, one-cycle valid / frame_err pulses.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample centre.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level on rx
// START     | validating the start bit at its centre
// DATA      | shifting in 8 data bits, LSB first
// STOP      | sampling the stop bit, then pulse valid or frame_err
// WAIT_HIGH | after a framing error, hold off until the line returns high
module uart_receive
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BAUD_PERIOD = baud_period(INPUT_CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_PERIOD = BAUD_PERIOD / 2;
  localparam int CNT_W       = $clog2(BAUD_PERIOD);
  localparam int IDX_W       = $clog2(DATA_BITS);

`ifdef UART_RX_MAJORITY_EN
  // The vote needs the sample after the centre, so every decision lands one clock late.
  localparam int START_TC = HALF_PERIOD;
`else
  localparam int START_TC = HALF_PERIOD - 1;
`endif

  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_TC);
  localparam logic [CNT_W-1:0] BIT_CNT   = CNT_W'(BAUD_PERIOD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic                 rx;
  logic                 sample;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_d;
  logic                 valid_d;
  logic                 ferr_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (rx)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rx};
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rx) | (hist[0] & rx);
`else
  assign sample = rx;
`endif

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = START;
      end
      START: begin
        if (cnt_q == START_CNT) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sample ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = sample;
          idx_d          = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d = '0;
          if (sample) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      dout      <= dout_d;
      valid     <= valid_d;
      frame_err <= ferr_d;
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Scoreboard bench for uart_receive: frame-level stimulus, expected events queued, monitor checks.
module tb_uart_receive;

  localparam int FREQ = 1_600_000;
  localparam int BAUD = 100_000;
  localparam int B    = FREQ / BAUD;
  localparam int H    = B / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT  = 9 * B + H + 4;
  localparam bit GLITCH = 1'b1;
`else
  localparam int LAT  = 9 * B + H + 3;
  localparam bit GLITCH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic [7:0] dout;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t0;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;

  uart_receive #(
    .INPUT_CLOCK_FREQ (FREQ),
    .BAUD_RATE        (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .dout      (dout),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bit period on the line, optionally with a one-clock inversion at its centre.
  task automatic drive_bit(input logic v, input bit glitch);
    din = v;
    if (glitch) begin
      tick(H);
      din = ~v;
      tick(1);
      din = v;
      tick(B - H - 1);
    end else begin
      tick(B);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch);
    exp_t e;
    e.err  = !stop;
    e.data = b;
    e.t0   = cyc;
    sb.push_back(e);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], glitch);
    drive_bit(stop, 1'b0);
    din = 1'b1;
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!rst) begin
      if (valid && frame_err) check("valid_ferr_exclusive", 1, 0);
      if (valid || frame_err) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b dout=0x%0h", valid, frame_err, dout);
        end else begin
          e = sb.pop_front();
          check("pulse_kind_ferr", frame_err, e.err);
          if (!e.err) begin
            check("rx_data", dout, e.data);
            check("busy_at_valid", busy, 0);
            lat = cyc - e.t0;
            total++;
            if (lat < LAT - 1 || lat > LAT + 1) begin
              bad++;
              $display("FAIL latency: got=%0d want=%0d", lat, LAT);
            end
            last_good = e.data;
          end else begin
            check("dout_hold_on_ferr", dout, last_good);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       stop;
    logic       any;

    rst = 1'b1;
    din = 1'b1;
    tick(4);
    rst = 1'b0;
    check("rst_dout", dout, 0);
    check("rst_valid", valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);

    // Idle line: nothing happens.
    any = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      any = any | busy | valid | frame_err;
      tick(1);
    end
    check("idle_quiet", any, 0);
    check("idle_dout", dout, 0);

    // Single frame.
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(B);
    check("busy_after_a5", busy, 0);

    // Back-to-back frames, as from a transmitter loopback.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(B);

    // Framing error followed by a held-low line.
    send_frame(8'h55, 1'b0, 1'b0);
    din = 1'b0;
    tick(3 * B);
    check("busy_while_low", busy, 1);
    din = 1'b1;
    tick(6);
    check("busy_after_high", busy, 0);
    tick(B);

    // Short low pulse is rejected as a glitch start.
    din = 1'b0;
    tick(4);
    din = 1'b1;
    tick(B);
    check("glitch_start_idle", busy, 0);
    send_frame(8'h81, 1'b1, 1'b0);
    tick(B);

    // Randomised frames, some with a bad stop bit, random idle gaps.
    for (int n = 0; n < 16; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(b, stop, 1'b0);
      if (!stop) tick(B);
      else       tick($urandom_range(0, 2) * H);
    end
    tick(2 * B);

    // Reset in the middle of a frame.
    b = 8'h96;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i], 1'b0);
    rst = 1'b1;
    tick(1);
    check("midrst_dout", dout, 0);
    check("midrst_valid", valid, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_busy", busy, 0);
    rst       = 1'b0;
    din       = 1'b1;
    last_good = 8'h00;
    tick(2 * B);
    send_frame(8'h96, 1'b1, GLITCH);

    for (int i = 0; i < 4 * B && sb.size() != 0; i++) tick(1);
    check("scoreboard_drained", sb.size(), 0);
    tick(B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
